// File: rtl/armleocpu_tlb_assoc_if.sv
// Command/response bundle between the page-table walker / fetch / LSU and the TLB.
// ASID signals and the ASID_W parameter exist only when ARMLEOCPU_TLB_ASID_EN is defined.
interface armleocpu_tlb_assoc_if #(
  parameter int unsigned ENTRIES_W = 4
`ifdef ARMLEOCPU_TLB_ASID_EN
  , parameter int unsigned ASID_W = 9
`endif
);
  logic [1:0]           command;
  logic                 invalidate_all;
  logic [ENTRIES_W-1:0] invalidate_set_index;
  logic [19:0]          virtual_address;
  logic [19:0]          virtual_address_w;
  logic [7:0]           accesstag_w;
  logic [21:0]          phys_w;
`ifdef ARMLEOCPU_TLB_ASID_EN
  logic [ASID_W-1:0]    asid;
  logic [ASID_W-1:0]    asid_w;
`endif
  logic                 busy;
  logic                 hit;
  logic [7:0]           accesstag_r;
  logic [21:0]          phys_r;

  modport master (
    output command, invalidate_all, invalidate_set_index, virtual_address, virtual_address_w,
    output accesstag_w, phys_w,
`ifdef ARMLEOCPU_TLB_ASID_EN
    output asid, asid_w,
`endif
    input  busy, hit, accesstag_r, phys_r
  );

  modport slave (
    input  command, invalidate_all, invalidate_set_index, virtual_address, virtual_address_w,
    input  accesstag_w, phys_w,
`ifdef ARMLEOCPU_TLB_ASID_EN
    input  asid, asid_w,
`endif
    output busy, hit, accesstag_r, phys_r
  );
endinterface

// File: rtl/armleocpu_tlb_assoc.sv
// Set-associative TLB with per-set round-robin replacement and a multi-cycle flush-all FSM.
// Optional ASID tagging is enabled by defining ARMLEOCPU_TLB_ASID_EN.
module armleocpu_tlb_assoc #(
  parameter int unsigned ENTRIES_W = 4,
  parameter int unsigned WAYS_W    = 1
`ifdef ARMLEOCPU_TLB_ASID_EN
  , parameter int unsigned ASID_W  = 9
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  armleocpu_tlb_assoc_if.slave tlb_io
);

  localparam int unsigned Sets = 1 << ENTRIES_W;
  localparam int unsigned Ways = 1 << WAYS_W;
  localparam int unsigned RrW  = (WAYS_W > 0) ? WAYS_W : 1;
  localparam int unsigned TagW = 20 - ENTRIES_W;

  localparam logic [1:0] CmdNone       = 2'b00;
  localparam logic [1:0] CmdResolve    = 2'b01;
  localparam logic [1:0] CmdWrite      = 2'b10;
  localparam logic [1:0] CmdInvalidate = 2'b11;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e                    state_q, state_d;
  logic [ENTRIES_W-1:0]      flush_idx_q, flush_idx_d;
  logic [Sets-1:0][Ways-1:0] valid_q, valid_d;
  logic [Sets-1:0][RrW-1:0]  rr_q, rr_d;
  logic                      hit_q, hit_d;
  logic [7:0]                acc_q, acc_d;
  logic [21:0]               phys_q, phys_d;

  logic [TagW-1:0] tag_mem  [Sets][Ways];
  logic [7:0]      acc_mem  [Sets][Ways];
  logic [21:0]     phys_mem [Sets][Ways];
`ifdef ARMLEOCPU_TLB_ASID_EN
  logic [ASID_W-1:0] asid_mem [Sets][Ways];
`endif

  // Resolve lookup
  logic [ENTRIES_W-1:0] rd_set;
  logic [TagW-1:0]      rd_tag;
  logic                 rd_hit;
  logic [7:0]           rd_acc;
  logic [21:0]          rd_phys;

  assign rd_set = tlb_io.virtual_address[ENTRIES_W-1:0];
  assign rd_tag = tlb_io.virtual_address[19:ENTRIES_W];

  always_comb begin
    rd_hit  = 1'b0;
    rd_acc  = '0;
    rd_phys = '0;
    for (int unsigned w = 0; w < Ways; w++) begin
      if (valid_q[rd_set][w] && (tag_mem[rd_set][w] == rd_tag)
`ifdef ARMLEOCPU_TLB_ASID_EN
          && ((asid_mem[rd_set][w] == tlb_io.asid) || acc_mem[rd_set][w][5])
`endif
          ) begin
        rd_hit  = 1'b1;
        rd_acc  = acc_mem[rd_set][w];
        rd_phys = phys_mem[rd_set][w];
      end
    end
  end

  // Write way selection: existing match, else lowest invalid way, else round-robin victim
  logic [ENTRIES_W-1:0] wr_set;
  logic [TagW-1:0]      wr_tag;
  logic                 wr_match, wr_free, wr_en;
  logic [RrW-1:0]       wr_match_way, wr_free_way, wr_way, rr_inc;

  assign wr_set = tlb_io.virtual_address_w[ENTRIES_W-1:0];
  assign wr_tag = tlb_io.virtual_address_w[19:ENTRIES_W];

  always_comb begin
    wr_match     = 1'b0;
    wr_match_way = '0;
    wr_free      = 1'b0;
    wr_free_way  = '0;
    for (int unsigned w = 0; w < Ways; w++) begin
      if (valid_q[wr_set][w] && (tag_mem[wr_set][w] == wr_tag)
`ifdef ARMLEOCPU_TLB_ASID_EN
          && (asid_mem[wr_set][w] == tlb_io.asid_w)
`endif
          ) begin
        wr_match     = 1'b1;
        wr_match_way = RrW'(w);
      end
      if (!wr_free && !valid_q[wr_set][w]) begin
        wr_free     = 1'b1;
        wr_free_way = RrW'(w);
      end
    end
  end

  assign wr_way = wr_match ? wr_match_way : (wr_free ? wr_free_way : rr_q[wr_set]);
  assign rr_inc = RrW'((32'(rr_q[wr_set]) + 32'd1) % Ways);

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    hit_d       = hit_q;
    acc_d       = acc_q;
    phys_d      = phys_q;
    wr_en       = 1'b0;
    case (state_q)
      StIdle: begin
        case (tlb_io.command)
          CmdNone: ;
          CmdResolve: begin
            hit_d  = rd_hit;
            acc_d  = rd_acc;
            phys_d = rd_phys;
          end
          CmdWrite: begin
            wr_en                   = 1'b1;
            valid_d[wr_set][wr_way] = 1'b1;
            if (!wr_match && !wr_free) begin
              rr_d[wr_set] = rr_inc;
            end
          end
          CmdInvalidate: begin
            if (tlb_io.invalidate_all) begin
              state_d     = StFlush;
              flush_idx_d = '0;
              hit_d       = 1'b0;
              acc_d       = '0;
              phys_d      = '0;
            end else begin
              valid_d[tlb_io.invalidate_set_index] = '0;
            end
          end
        endcase
      end
      StFlush: begin
        valid_d[flush_idx_q] = '0;
        flush_idx_d          = flush_idx_q + 1'b1;
        if (&flush_idx_q) begin
          state_d = StIdle;
          rr_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      flush_idx_q <= '0;
      valid_q     <= '0;
      rr_q        <= '0;
      hit_q       <= 1'b0;
      acc_q       <= '0;
      phys_q      <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      hit_q       <= hit_d;
      acc_q       <= acc_d;
      phys_q      <= phys_d;
    end
  end

  // Payload arrays are qualified by valid bits, so they carry no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_set][wr_way]  <= wr_tag;
      acc_mem[wr_set][wr_way]  <= tlb_io.accesstag_w;
      phys_mem[wr_set][wr_way] <= tlb_io.phys_w;
`ifdef ARMLEOCPU_TLB_ASID_EN
      asid_mem[wr_set][wr_way] <= tlb_io.asid_w;
`endif
    end
  end

  assign tlb_io.busy        = (state_q == StFlush);
  assign tlb_io.hit         = hit_q;
  assign tlb_io.accesstag_r = acc_q;
  assign tlb_io.phys_r      = phys_q;

endmodule

// File: tb/tb_armleocpu_tlb_assoc.sv
// Scoreboard bench for armleocpu_tlb_assoc: directed sequence then randomized traffic
// against a behavioural TLB model.
module tb_armleocpu_tlb_assoc;
  localparam int unsigned EW   = 1;
  localparam int unsigned WW   = 1;
  localparam int          Sets = 1 << EW;
  localparam int          Ways = 1 << WW;

  localparam logic [1:0] CNone = 2'b00, CRes = 2'b01, CWr = 2'b10, CInv = 2'b11;

  typedef struct packed {
    logic        busy;
    logic        hit;
    logic [7:0]  acc;
    logic [21:0] phys;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ARMLEOCPU_TLB_ASID_EN
  armleocpu_tlb_assoc_if #(.ENTRIES_W(EW), .ASID_W(9)) tlb_if ();
  armleocpu_tlb_assoc #(.ENTRIES_W(EW), .WAYS_W(WW), .ASID_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .tlb_io(tlb_if)
  );
  initial begin
    tlb_if.asid   = '0;
    tlb_if.asid_w = '0;
  end
`else
  armleocpu_tlb_assoc_if #(.ENTRIES_W(EW)) tlb_if ();
  armleocpu_tlb_assoc #(.ENTRIES_W(EW), .WAYS_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .tlb_io(tlb_if)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;
  resp_t exp_q[$];

  // Behavioural model: full VPNs per way, busy modelled as a countdown
  bit          m_valid [Sets][Ways];
  logic [19:0] m_vpn   [Sets][Ways];
  logic [7:0]  m_acc   [Sets][Ways];
  logic [21:0] m_phys  [Sets][Ways];
  int          m_rr    [Sets];
  int          m_busy_cnt;
  resp_t       m_out;

  task automatic model_reset();
    for (int s = 0; s < Sets; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < Ways; w++) m_valid[s][w] = 0;
    end
    m_busy_cnt = 0;
    m_out      = '0;
  endtask

  task automatic model_step(input logic [1:0] cmd, input logic all, input int idx,
                            input logic [19:0] va, input logic [19:0] vaw,
                            input logic [7:0] acc, input logic [21:0] phys);
    int s, way;
    if (m_busy_cnt > 0) begin
      m_busy_cnt--;
    end else if (cmd == CRes) begin
      s = int'(va) % Sets;
      m_out.hit = 0; m_out.acc = '0; m_out.phys = '0;
      for (int w = 0; w < Ways; w++)
        if (m_valid[s][w] && m_vpn[s][w] == va) begin
          m_out.hit = 1; m_out.acc = m_acc[s][w]; m_out.phys = m_phys[s][w];
        end
    end else if (cmd == CWr) begin
      s = int'(vaw) % Sets;
      way = -1;
      for (int w = 0; w < Ways; w++) if (m_valid[s][w] && m_vpn[s][w] == vaw) way = w;
      if (way < 0) for (int w = Ways - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) begin
        way = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % Ways;
      end
      m_valid[s][way] = 1; m_vpn[s][way] = vaw; m_acc[s][way] = acc; m_phys[s][way] = phys;
    end else if (cmd == CInv) begin
      if (all) begin
        for (int t = 0; t < Sets; t++) begin
          m_rr[t] = 0;
          for (int w = 0; w < Ways; w++) m_valid[t][w] = 0;
        end
        m_busy_cnt = Sets;
        m_out = '0;
      end else begin
        for (int w = 0; w < Ways; w++) m_valid[idx][w] = 0;
      end
    end
    m_out.busy = (m_busy_cnt > 0);
  endtask

  // Drive one clock cycle; called at a negedge, returns at the next negedge
  task automatic cycle(input logic [1:0] cmd, input logic all, input int idx,
                       input logic [19:0] va, input logic [19:0] vaw,
                       input logic [7:0] acc, input logic [21:0] phys);
    tlb_if.command              = cmd;
    tlb_if.invalidate_all       = all;
    tlb_if.invalidate_set_index = EW'(idx);
    tlb_if.virtual_address      = va;
    tlb_if.virtual_address_w    = vaw;
    tlb_if.accesstag_w          = acc;
    tlb_if.phys_w               = phys;
    model_step(cmd, all, idx, va, vaw, acc, phys);
    exp_q.push_back(m_out);
    @(negedge clk);
  endtask

  task automatic wr(input logic [19:0] vaw, input logic [21:0] phys, input logic [7:0] acc);
    cycle(CWr, 1'b0, 0, 20'h0, vaw, acc, phys);
  endtask

  task automatic res(input logic [19:0] va);
    cycle(CRes, 1'b0, 0, va, 20'h0, 8'h0, 22'h0);
  endtask

  task automatic inv(input logic all, input int idx);
    cycle(CInv, all, idx, 20'h0, 20'h0, 8'h0, 22'h0);
  endtask

  task automatic idle();
    cycle(CNone, 1'b0, 0, 20'h0, 20'h0, 8'h0, 22'h0);
  endtask

  task automatic do_reset();
    resp_t act;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    act = {tlb_if.busy, tlb_if.hit, tlb_if.accesstag_r, tlb_if.phys_r};
    n_tests++;
    if (act !== resp_t'('0)) begin
      n_fail++;
      $display("FAIL reset: got %h, expected %h", act, resp_t'('0));
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: every active edge out of reset yields one expected response
  initial begin
    resp_t act, exp;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        #1;
        act = {tlb_if.busy, tlb_if.hit, tlb_if.accesstag_r, tlb_if.phys_r};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL outputs: got %h, expected nothing (scoreboard empty)", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp)  begin
            n_fail++;
            $display("FAIL outputs @%0t: got busy=%b hit=%b acc=%h phys=%h, expected busy=%b hit=%b acc=%h phys=%h",
                     $time, act.busy, act.hit, act.acc, act.phys,
                     exp.busy, exp.hit, exp.acc, exp.phys);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [19:0] va;
    tlb_if.command = CNone;
    tlb_if.invalidate_all = 1'b0;
    tlb_if.invalidate_set_index = '0;
    tlb_if.virtual_address = '0;
    tlb_if.virtual_address_w = '0;
    tlb_if.accesstag_w = '0;
    tlb_if.phys_w = '0;
    @(negedge clk);
    do_reset();

    inv(1'b1, 0); idle(); idle(); idle();
    res(20'h55);
    wr(20'h100, 22'hF5, 8'hFF); wr(20'h102, 22'hF6, 8'hFF);
    res(20'h100); res(20'h102);
    wr(20'h104, 22'hF7, 8'hFF);
    res(20'h100); res(20'h102); res(20'h104);
    wr(20'h102, 22'hFA, 8'hFF);
    res(20'h102); res(20'h104);
    wr(20'h106, 22'hF8, 8'h3C);
    res(20'h102); res(20'h104); res(20'h106);
    wr(20'h101, 22'hE1, 8'hFF);
    inv(1'b0, 0);
    res(20'h102); res(20'h104); res(20'h101);
    idle();
    // Commands during a flush are ignored
    inv(1'b1, 0); res(20'h101); wr(20'h103, 22'h33, 8'h01);
    res(20'h101); res(20'h103);
    // Reset in the middle of a flush
    wr(20'h105, 22'h55, 8'h0F);
    inv(1'b1, 0);
    do_reset();
    res(20'h105); idle();

    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      va = 20'h100 + 20'($urandom_range(0, 7));
      if (r < 40)      res(va);
      else if (r < 75) wr(va, 22'($urandom), 8'($urandom));
      else if (r < 88) inv(1'b0, int'($urandom_range(0, Sets - 1)));
      else if (r < 93) inv(1'b1, 0);
      else             idle();
    end
    idle();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
